// File: rtl/pipe_stage_chain.sv
// Parametrised chain of DEPTH payload/valid registers with per-stage stall, bubble and flush.
// Optional statistics counters are enabled with the PIPE_STAGE_CHAIN_STATS_EN macro.
module pipe_stage_chain #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 4,
    parameter int IDX_W = $clog2(DEPTH)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         in_valid,
    input  logic [WIDTH-1:0]             in_data,
    output logic                         in_ready,
    input  logic                         stall,
    input  logic [IDX_W-1:0]             stall_stage,
    input  logic                         flush,
    input  logic [IDX_W-1:0]             flush_stage,
    output logic [DEPTH-1:0]             stage_valid,
    output logic [DEPTH*WIDTH-1:0]       stage_data,
    output logic                         out_valid,
    output logic [WIDTH-1:0]             out_data,
    output logic                         out_fire,
    output logic [$clog2(DEPTH+1)-1:0]   occupancy,
    output logic [15:0]                  bubble_cnt,
    output logic [15:0]                  flush_cnt
);

    localparam int OCC_W = $clog2(DEPTH+1);

    logic [IDX_W-1:0] s_idx, f_idx;
    logic [DEPTH-1:0] kill_mask, hold_mask, bub_mask;
    logic [DEPTH-1:0] valid_w;
    logic [WIDTH-1:0] data_w [DEPTH];

    // Index values beyond the last stage behave as the last stage.
    if ((1 << IDX_W) > DEPTH) begin : g_clamp
        assign s_idx = (int'(stall_stage) >= DEPTH) ? IDX_W'(DEPTH-1) : stall_stage;
        assign f_idx = (int'(flush_stage) >= DEPTH) ? IDX_W'(DEPTH-1) : flush_stage;
    end else begin : g_noclamp
        assign s_idx = stall_stage;
        assign f_idx = flush_stage;
    end

    // Flush has priority, then hold, then the single bubble slot above the frozen range.
    always_comb begin
        kill_mask = '0;
        hold_mask = '0;
        bub_mask  = '0;
        for (int k = 0; k < DEPTH; k++) begin
            if (flush && k <= int'(f_idx)) begin
                kill_mask[k] = 1'b1;
            end else if (stall && k <= int'(s_idx)) begin
                hold_mask[k] = 1'b1;
            end else if (stall && k == int'(s_idx) + 1) begin
                bub_mask[k] = 1'b1;
            end
        end
    end

    for (genvar k = 0; k < DEPTH; k++) begin : g_stage
        logic             v_in, v_q;
        logic [WIDTH-1:0] d_in, d_q;

        if (k == 0) begin : g_head
            assign v_in = in_valid;
            assign d_in = in_data;
        end else begin : g_body
            assign v_in = valid_w[k-1];
            assign d_in = data_w[k-1];
        end

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                v_q <= 1'b0;
                d_q <= '0;
            end else if (kill_mask[k] || bub_mask[k]) begin
                v_q <= 1'b0;
                d_q <= '0;
            end else if (!hold_mask[k]) begin
                v_q <= v_in;
                d_q <= d_in;
            end
        end

        assign valid_w[k] = v_q;
        assign data_w[k]  = d_q;
        assign stage_data[k*WIDTH +: WIDTH] = d_q;
    end

    assign stage_valid = valid_w;
    assign out_valid   = valid_w[DEPTH-1];
    assign out_data    = data_w[DEPTH-1];
    assign in_ready    = ~stall & ~flush;
    assign out_fire    = valid_w[DEPTH-1] & ~(stall && s_idx == IDX_W'(DEPTH-1));

    always_comb begin
        occupancy = '0;
        for (int k = 0; k < DEPTH; k++) begin
            occupancy = occupancy + OCC_W'(valid_w[k]);
        end
    end

`ifdef PIPE_STAGE_CHAIN_STATS_EN
    logic [OCC_W-1:0] kill_cnt;
    logic [16:0]      flu_sum;
    logic [15:0]      bub_q, flu_q;

    always_comb begin
        kill_cnt = '0;
        for (int k = 0; k < DEPTH; k++) begin
            kill_cnt = kill_cnt + OCC_W'(kill_mask[k] & valid_w[k]);
        end
    end

    assign flu_sum = {1'b0, flu_q} + 17'(kill_cnt);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bub_q <= '0;
            flu_q <= '0;
        end else begin
            if (|bub_mask && bub_q != 16'hFFFF) begin
                bub_q <= bub_q + 16'd1;
            end
            flu_q <= flu_sum[16] ? 16'hFFFF : flu_sum[15:0];
        end
    end

    assign bubble_cnt = bub_q;
    assign flush_cnt  = flu_q;
`else
    assign bubble_cnt = '0;
    assign flush_cnt  = '0;
`endif

endmodule

// File: doc/pipe_stage_chain.md
Name: pipe_stage_chain

Overview:
- Parametrised, reusable replacement for the hand-instantiated per-stage pipeline buffers and their external stall, flush and NOP muxing.
- Implements a chain of DEPTH pipeline registers, each carrying a WIDTH-bit payload (packed control word plus data) and a valid bit.
- Stall, bubble insertion and flush are each selectable per stage index.
- Sits between the fetch source and the writeback sink; the hazard and forwarding logic drive its stall and flush controls.

Parameters:
WIDTH, 64, payload bits per stage (control word plus data fields).
DEPTH, 4, number of pipeline stages; must be ≥2. Stage 0 is the youngest; stage DEPTH-1 is the output.
IDX_W, $clog2(DEPTH), width of the stage-index ports; derived, do not override.

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous active-high reset
in_valid  in  1  new entry offered to stage 0
in_data  in  WIDTH  payload for stage 0
in_ready  out  1  entry accepted this cycle; equals ~stall & ~flush
stall  in  1  freeze stages 0..stall_stage
stall_stage  in  IDX_W  highest frozen stage index
flush  in  1  kill stages 0..flush_stage
flush_stage  in  IDX_W  highest flushed stage index
stage_valid  out  DEPTH  valid bit of every stage
stage_data  out  DEPTH*WIDTH  payload of every stage; stage k occupies bits [k*WIDTH +: WIDTH]
out_valid  out  1  equals stage_valid[DEPTH-1]
out_data  out  WIDTH  payload of stage DEPTH-1
out_fire  out  1  out_valid & ~(stall & stall_stage==DEPTH-1); asserted once per retirement
occupancy  out  $clog2(DEPTH+1)  combinational count of valid stages
bubble_cnt  out  16  bubbles inserted (see Optional Feature)
flush_cnt  out  16  valid entries killed by flush (see Optional Feature)

Behaviour:
- Reset (asynchronous, effective immediately without a clock edge):
  - all stage_valid = 0 and all stage data = 0;
  - counters = 0;
  - in_ready and out_valid therefore follow from the combinational equations.
- Normal advance (no stall, no flush):
  - stage k+1 ← stage k;
  - stage 0 ← {in_valid, in_data};
  - an entry accepted at edge t sits in stage k after edge t+k, so out_valid is first high in the cycle following edge t+DEPTH-1.
- Stall (stall=1, S=stall_stage):
  - stages 0..S hold value and valid;
  - if S<DEPTH-1, stage S+1 loads a bubble (valid=0, data=all zeros, i.e. a NOP control word);
  - stages above S+1 advance normally;
  - in_ready=0 and in_data is ignored.
- Flush (flush=1, F=flush_stage):
  - stages 0..F load valid=0, data=0;
  - in_ready=0;
  - stages above F follow the stall/advance rules.
- Stall and flush together:
  - flush wins for every stage ≤ F;
  - if S+1 ≤ F, no bubble is counted (the flush covers that stage).
- stall_stage = DEPTH-1: the whole chain freezes, out_data/out_valid are repeated, and out_fire=0.
- The chain has no output backpressure; the sink always consumes when out_fire=1.
- Out-of-range index values (≥DEPTH when DEPTH is not a power of 2) are treated as DEPTH-1.
- Implementation is a single always_ff per stage array with a generate loop; no combinational path from in_data to out_data when DEPTH ≥2.

Optional Feature:
Macro PIPE_STAGE_CHAIN_STATS_EN.
- Defined:
  - bubble_cnt increments on every edge where a bubble is inserted into a stage that is not simultaneously flushed;
  - flush_cnt adds the number of valid stages killed that edge (0..DEPTH);
  - both saturate at 16'hFFFF and clear only on rst.
- Undefined: bubble_cnt and flush_cnt are tied to 0 and no counter flops are synthesised.

Test Plan (WIDTH=16, DEPTH=4, stats enabled):
1. Stream 0x0001..0x0006 with in_valid=1, accepted on edges 1..6, no stall → out_valid first high after edge 4 with out_data=0x0001; then 0x0002..0x0006 on consecutive cycles; occupancy=4 in steady state.
2. Chain holds A=0x00A0 (s1), B=0x00B0 (s0); pulse stall=1, stall_stage=1 for one cycle → A and B hold, in_ready=0, s2 becomes valid=0 with data 0x0000, bubble_cnt=1; the next edge resumes normally.
3. All stages valid; apply stall=1, stall_stage=1 together with flush=1, flush_stage=2 → stages 0..2 become valid=0, stage 3 receives the old s2 contents, flush_cnt=3, bubble_cnt unchanged.
4. stall=1, stall_stage=3 held for 3 cycles with full chain → stage_data unchanged, out_fire=0 throughout, bubble_cnt unchanged; releasing stall gives out_fire=1 on the next cycle.
5. Assert rst asynchronously mid-stream, between clock edges → stage_valid=4'b0000 and occupancy=0 before the next edge; after deassertion the first accepted entry reaches the output DEPTH edges later.
6. Force 65537 bubble insertions → bubble_cnt saturates at 0xFFFF; a rebuild without the macro shows bubble_cnt=0 and flush_cnt=0 under the same stimulus.
